// File: rtl/jpeg_stream_packer.sv
// jpeg_stream_packer
//   Takes IN_W-bit words from the JPEG encoder, queues them in a small FIFO,
//   serialises them MSB-first into bytes, inserts 0x00 after every 0xFF data
//   byte (when STUFF_EN=1), pads the final partial byte with 1s and repacks
//   the byte stream into OUT_W-bit words with valid/ready flow control.
//
// Ports
//   clk, rst            clock (rising edge), async active-low reset
//   enable              0 = synchronous clear of every piece of state
//   in_data/in_valid    full input word push
//   in_eof/in_eof_bits  final word push, in_eof_bits valid MSBs (0..IN_W)
//   out_data/out_keep   packed output, first byte / lane in the MSBs
//   out_valid/out_ready output handshake
//   out_last            last word of the image
//   level, overflow     FIFO occupancy, sticky "word dropped on full FIFO"
//   dbg_state           byte engine state (IDLE=0, SHIFT=1, STUFF=2, FLUSH=3)
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both 1. Once out_valid is raised, out_data/out_keep/out_last
// hold and out_valid stays high until that transfer (or reset / enable=0).
module jpeg_stream_packer #(
  parameter int IN_W     = 32,
  parameter int OUT_W    = 8,
  parameter int DEPTH    = 16,
  parameter bit STUFF_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_valid,
  input  logic                     in_eof,
  input  logic [$clog2(IN_W):0]    in_eof_bits,
  output logic [OUT_W-1:0]         out_data,
  output logic [OUT_W/8-1:0]       out_keep,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [1:0]               dbg_state
);

  localparam int LANES = OUT_W / 8;
  localparam int BYTES = IN_W / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int EBW   = $clog2(IN_W) + 1;
  localparam int NBW   = $clog2(BYTES) + 1;
  localparam int LCW   = $clog2(LANES) + 1;
  localparam int EW    = IN_W + 1 + NBW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_STUFF = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  // ---------------------------------------------------------------- FIFO
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            push_req, push_ok, pop, fifo_full, fifo_empty;
  logic [EBW:0]    eof_sum;
  logic [NBW-1:0]  push_nb;
  logic [IN_W-1:0] eof_fill;
  logic [EW-1:0]   wr_entry, rd_entry;
  logic [IN_W-1:0] rd_data;
  logic            rd_eof;
  logic [NBW-1:0]  rd_nb;

  assign fifo_full  = (count_q == (AW+1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push_req   = enable && (in_valid || in_eof);
  // A push into a full FIFO still lands when the byte engine pops the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);

  // nbytes = ceil(bits/8); all bits below the valid MSBs become 1 so the
  // last partial byte is padded with 1s before the stuffing check sees it.
  assign eof_sum  = {1'b0, in_eof_bits} + (EBW+1)'(7);
  assign push_nb  = in_eof ? NBW'(eof_sum >> 3) : NBW'(BYTES);
  assign eof_fill = in_data | ({IN_W{1'b1}} >> in_eof_bits);
  assign wr_entry = {(in_eof ? eof_fill : in_data), in_eof, push_nb};

  assign rd_entry = mem_q[rd_ptr_q];
  assign rd_data  = rd_entry[EW-1 -: IN_W];
  assign rd_eof   = rd_entry[NBW];
  assign rd_nb    = rd_entry[NBW-1:0];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) overflow_d = 1'b1;
    if (!enable) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_entry;
  end

  // --------------------------------------------------- byte engine + packer
  logic [1:0]       state_q, state_d;
  logic [IN_W-1:0]  sh_q, sh_d;
  logic [NBW-1:0]   rem_q, rem_d;
  logic             eof_q, eof_d;
  logic [OUT_W-1:0] pk_data_q, pk_data_d;
  logic [LCW-1:0]   pk_cnt_q, pk_cnt_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0] out_keep_q, out_keep_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic             can_accept, byte_vld, flush_go, word_done;
  logic [7:0]       byte_val;
  logic [OUT_W-1:0] new_word;
  logic [LANES-1:0] flush_keep;

  // The output register is the only hand-off point, so a new byte (or the
  // flush word) may only move when it is empty or being drained this cycle.
  assign can_accept = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    rem_d       = rem_q;
    eof_d       = eof_q;
    pk_data_d   = pk_data_q;
    pk_cnt_d    = pk_cnt_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    pop         = 1'b0;
    byte_vld    = 1'b0;
    byte_val    = 8'h00;
    flush_go    = 1'b0;
    word_done   = 1'b0;
    new_word    = pk_data_q;
    flush_keep  = '0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      S_SHIFT: begin
        if (can_accept) begin
          byte_vld = 1'b1;
          byte_val = sh_q[IN_W-1 -: 8];
          sh_d     = sh_q << 8;
          rem_d    = rem_q - NBW'(1);
          if (STUFF_EN && (sh_q[IN_W-1 -: 8] == 8'hFF)) state_d = S_STUFF;
          else if (rem_q == NBW'(1))                   word_done = 1'b1;
        end
      end
      S_STUFF: begin
        if (can_accept) begin
          byte_vld = 1'b1;
          byte_val = 8'h00;
          if (rem_q == '0) word_done = 1'b1;
          else             state_d   = S_SHIFT;
        end
      end
      default: begin // S_FLUSH
        if (can_accept) begin
          flush_go = 1'b1;
          state_d  = S_IDLE;
        end
      end
    endcase

    // End of a word: close the image, or chain straight into the next word.
    if (word_done) begin
      if (eof_q)            state_d = S_FLUSH;
      else if (!fifo_empty) pop     = 1'b1;
      else                  state_d = S_IDLE;
    end

    if (pop) begin
      sh_d    = rd_data;
      rem_d   = rd_nb;
      eof_d   = rd_eof;
      // An empty eof word has no bytes; go straight to closing the image.
      state_d = (rd_eof && (rd_nb == '0)) ? S_FLUSH : S_SHIFT;
    end

    if (byte_vld) begin
      for (int i = 0; i < LANES; i++) begin
        if (pk_cnt_q == LCW'(i)) new_word[OUT_W-1-8*i -: 8] = byte_val;
      end
      if (pk_cnt_q == LCW'(LANES-1)) begin
        out_data_d  = new_word;
        out_keep_d  = '1;
        out_last_d  = 1'b0;
        out_valid_d = 1'b1;
        pk_data_d   = '0;
        pk_cnt_d    = '0;
      end else begin
        pk_data_d = new_word;
        pk_cnt_d  = pk_cnt_q + LCW'(1);
      end
    end

    for (int i = 0; i < LANES; i++) begin
      flush_keep[LANES-1-i] = (LCW'(i) < pk_cnt_q);
    end

    // The closing word always goes out, even with no lanes filled, so the
    // sink always sees a last marker.
    if (flush_go) begin
      out_data_d  = pk_data_q;
      out_keep_d  = flush_keep;
      out_last_d  = 1'b1;
      out_valid_d = 1'b1;
      pk_data_d   = '0;
      pk_cnt_d    = '0;
    end

    if (!enable) begin
      state_d     = S_IDLE;
      sh_d        = '0;
      rem_d       = '0;
      eof_d       = 1'b0;
      pk_data_d   = '0;
      pk_cnt_d    = '0;
      out_data_d  = '0;
      out_keep_d  = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      state_q     <= S_IDLE;
      sh_q        <= '0;
      rem_q       <= '0;
      eof_q       <= 1'b0;
      pk_data_q   <= '0;
      pk_cnt_q    <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      sh_q        <= sh_d;
      rem_q       <= rem_d;
      eof_q       <= eof_d;
      pk_data_q   <= pk_data_d;
      pk_cnt_q    <= pk_cnt_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign level     = count_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_jpeg_stream_packer.sv
// tb_jpeg_stream_packer
//   Two instances: A (OUT_W=8, DEPTH=4, stuffing on) and
//   B (OUT_W=32, DEPTH=16, stuffing off). Every expected output word is
//   queued in exp_*_q and matched in order against the handshakes.
module tb_jpeg_stream_packer;

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b1;
  always #5 clk = ~clk;

  // ------------------------------------------------------ instance A
  logic [31:0] a_in_data = '0;
  logic        a_in_valid = 1'b0;
  logic        a_in_eof = 1'b0;
  logic [5:0]  a_in_eof_bits = '0;
  logic [7:0]  a_out_data;
  logic [0:0]  a_out_keep;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic        a_out_last;
  logic [2:0]  a_level;
  logic        a_overflow;
  logic [1:0]  a_dbg;
  logic        a_rand = 1'b0;
  logic        a_hold = 1'b1;

  jpeg_stream_packer #(.IN_W(32), .OUT_W(8), .DEPTH(4), .STUFF_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .enable(enable),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_eof(a_in_eof),
    .in_eof_bits(a_in_eof_bits),
    .out_data(a_out_data), .out_keep(a_out_keep), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_last(a_out_last),
    .level(a_level), .overflow(a_overflow), .dbg_state(a_dbg)
  );

  // ------------------------------------------------------ instance B
  logic [31:0] b_in_data = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_eof = 1'b0;
  logic [5:0]  b_in_eof_bits = '0;
  logic [31:0] b_out_data;
  logic [3:0]  b_out_keep;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic        b_out_last;
  logic [4:0]  b_level;
  logic        b_overflow;
  logic [1:0]  b_dbg;

  jpeg_stream_packer #(.IN_W(32), .OUT_W(32), .DEPTH(16), .STUFF_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .enable(enable),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_eof(b_in_eof),
    .in_eof_bits(b_in_eof_bits),
    .out_data(b_out_data), .out_keep(b_out_keep), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_last(b_out_last),
    .level(b_level), .overflow(b_overflow), .dbg_state(b_dbg)
  );

  // A's ready changes only just after a rising edge.
  always @(posedge clk) begin
    #1;
    a_out_ready = a_rand ? 1'($urandom_range(0, 1)) : a_hold;
  end

  // ------------------------------------------------------ scoreboard
  int total = 0;
  int bad   = 0;
  logic [9:0]  exp_a_q[$];   // {data, keep, last}
  logic [36:0] exp_b_q[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // ------------------------------------------------------ drivers
  task automatic push_a(input logic [31:0] d, input logic v, input logic e, input logic [5:0] bits);
    a_in_data = d; a_in_valid = v; a_in_eof = e; a_in_eof_bits = bits;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_eof = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] d, input logic v, input logic e, input logic [5:0] bits);
    b_in_data = d; b_in_valid = v; b_in_eof = e; b_in_eof_bits = bits;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_eof = 1'b0;
  endtask

  task automatic exp_byte_a(input logic [7:0] b);
    exp_a_q.push_back({b, 1'b1, 1'b0});
  endtask

  // Match A handshakes against exp_a_q; also check that a stalled word holds.
  task automatic drain_a(input int budget);
    int cyc;
    logic stalled;
    logic [9:0] held, got, exp;
    cyc = 0; stalled = 1'b0; held = '0;
    while (exp_a_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      got = {a_out_data, a_out_keep, a_out_last};
      if (stalled) begin
        total++;
        if (!a_out_valid || got !== held) begin
          bad++;
          $display("FAIL a_stall_hold got v=%0b w=%h exp v=1 w=%h", a_out_valid, got, held);
        end
      end
      stalled = a_out_valid && !a_out_ready;
      held = got;
      if (a_out_valid && a_out_ready) begin
        exp = exp_a_q.pop_front();
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL a_out got={%h,%b,%b} exp={%h,%b,%b}",
                   got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
        end
      end
    end
    if (exp_a_q.size() != 0) begin
      total++; bad++;
      $display("FAIL a_timeout got=%0d words left exp=0", exp_a_q.size());
      exp_a_q.delete();
    end
  endtask

  task automatic drain_b(input int budget);
    int cyc;
    logic [36:0] got, exp;
    cyc = 0;
    while (exp_b_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      got = {b_out_data, b_out_keep, b_out_last};
      if (b_out_valid && b_out_ready) begin
        exp = exp_b_q.pop_front();
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL b_out got={%h,%h,%b} exp={%h,%h,%b}",
                   got[36:5], got[4:1], got[0], exp[36:5], exp[4:1], exp[0]);
        end
      end
    end
    if (exp_b_q.size() != 0) begin
      total++; bad++;
      $display("FAIL b_timeout got=%0d words left exp=0", exp_b_q.size());
      exp_b_q.delete();
    end
  endtask

  task automatic quiet_a(input string nm);
    repeat (3) @(negedge clk);
    chk(nm, 64'({a_out_valid, a_level}), 64'd0);
  endtask

  task automatic quiet_b(input string nm);
    repeat (3) @(negedge clk);
    chk(nm, 64'({b_out_valid, b_level}), 64'd0);
  endtask

  // ------------------------------------------------------ vector table (A)
  typedef struct {
    logic [31:0] din;
    logic        eof;
    logic [5:0]  bits;
    int          nb;     // bytes expected after stuffing
    logic [63:0] exp;    // those bytes, first in the MSBs
  } vec_t;
  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [63:0] eb;

    vecs[0] = '{32'h12345678, 1'b0, 6'd0,  4, 64'h12345678_00000000};
    vecs[1] = '{32'hFF00FFAB, 1'b0, 6'd0,  6, 64'hFF0000FF_00AB0000};
    vecs[2] = '{32'hFFFFFFFF, 1'b0, 6'd0,  8, 64'hFF00FF00_FF00FF00};
    vecs[3] = '{32'h00000000, 1'b0, 6'd0,  4, 64'h00000000_00000000};
    vecs[4] = '{32'hA5FF5A01, 1'b0, 6'd0,  5, 64'hA5FF005A_01000000};
    vecs[5] = '{32'hFE000000, 1'b1, 6'd7,  2, 64'hFF000000_00000000}; // pad bit makes FF
    vecs[6] = '{32'hABC00000, 1'b1, 6'd12, 2, 64'hABCF0000_00000000};
    vecs[7] = '{32'h40000000, 1'b1, 6'd2,  1, 64'h7F000000_00000000};
    vecs[8] = '{32'h00000000, 1'b1, 6'd0,  0, 64'h00000000_00000000};
    vecs[9] = '{32'h123456FF, 1'b1, 6'd32, 5, 64'h123456FF_00000000};

    // ---------------- reset state
    repeat (2) @(negedge clk);
    chk("a_reset", 64'({a_out_data, a_out_keep, a_out_valid, a_out_last, a_level, a_overflow, a_dbg}), 64'd0);
    chk("b_reset", 64'({b_out_data, b_out_keep, b_out_valid, b_out_last, b_level, b_overflow, b_dbg}), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- T1: latency of the first byte, then the rest
    push_a(32'h12345678, 1'b1, 1'b0, 6'd0);
    @(negedge clk); chk("t1_lat_c1", 64'(a_out_valid), 64'd0);
    @(negedge clk); chk("t1_lat_c2", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    chk("t1_first", 64'({a_out_valid, a_out_data, a_out_keep, a_out_last}), 64'({1'b1, 8'h12, 1'b1, 1'b0}));
    exp_byte_a(8'h34); exp_byte_a(8'h56); exp_byte_a(8'h78);
    drain_a(40);
    quiet_a("t1_quiet");

    // ---------------- table: single words / images through A
    for (int v = 0; v < NV; v++) begin
      eb = vecs[v].exp;
      for (int i = 0; i < vecs[v].nb; i++) exp_byte_a(eb[63-8*i -: 8]);
      if (vecs[v].eof) exp_a_q.push_back({8'h00, 1'b0, 1'b1});
      push_a(vecs[v].din, !vecs[v].eof, vecs[v].eof, vecs[v].bits);
      drain_a(60);
      quiet_a("vec_quiet");
    end

    // ---------------- T4: overflow with the sink stalled
    // The first word is already in the byte engine (one byte waiting in the
    // output register), so four more fill the FIFO and the sixth is dropped.
    a_hold = 1'b0;
    @(negedge clk);
    push_a(32'h01020304, 1'b1, 1'b0, 6'd0);
    push_a(32'h05060708, 1'b1, 1'b0, 6'd0);
    push_a(32'h090A0B0C, 1'b1, 1'b0, 6'd0);
    push_a(32'h0D0E0F10, 1'b1, 1'b0, 6'd0);
    push_a(32'h11121314, 1'b1, 1'b0, 6'd0);
    push_a(32'hEEEEEEEE, 1'b1, 1'b0, 6'd0);
    @(negedge clk);
    chk("t4_level", 64'(a_level), 64'd4);
    chk("t4_overflow", 64'(a_overflow), 64'd1);
    chk("t4_stall_word", 64'({a_out_valid, a_out_data}), 64'({1'b1, 8'h01}));
    for (int i = 1; i <= 20; i++) exp_byte_a(8'(i));
    a_hold = 1'b1;
    drain_a(100);
    quiet_a("t4_quiet");
    chk("t4_ovf_sticky", 64'(a_overflow), 64'd1);

    // ---------------- enable=0 clears and ignores pushes
    enable = 1'b0;
    push_a(32'h99999999, 1'b1, 1'b0, 6'd0);
    @(negedge clk);
    chk("en_clear", 64'({a_level, a_overflow, a_out_valid, a_dbg}), 64'd0);
    enable = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    chk("en_ignored_push", 64'(seen), 64'd0);

    // ---------------- T6: random ready, then reset in the middle of a word
    a_rand = 1'b1;
    exp_byte_a(8'h11); exp_byte_a(8'h22); exp_byte_a(8'h33); exp_byte_a(8'h44);
    exp_byte_a(8'h55); exp_byte_a(8'h66); exp_byte_a(8'h77); exp_byte_a(8'h88);
    exp_byte_a(8'hFF); exp_byte_a(8'h00); exp_byte_a(8'hAA); exp_byte_a(8'h55);
    exp_byte_a(8'h00);
    push_a(32'h11223344, 1'b1, 1'b0, 6'd0);
    push_a(32'h55667788, 1'b1, 1'b0, 6'd0);
    push_a(32'hFFAA5500, 1'b1, 1'b0, 6'd0);
    drain_a(300);
    quiet_a("t6_quiet");
    push_a(32'hCAFEBABE, 1'b1, 1'b0, 6'd0);
    push_a(32'h01020304, 1'b1, 1'b0, 6'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_rst_outputs", 64'({a_out_data, a_out_keep, a_out_valid, a_out_last, a_level, a_overflow, a_dbg}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    chk("t6_discarded", 64'(seen), 64'd0);
    chk("t6_level", 64'(a_level), 64'd0);
    a_rand = 1'b0;
    a_hold = 1'b1;

    // ---------------- B: 32-bit lanes, no stuffing
    exp_b_q.push_back({32'hFF00FFAB, 4'hF, 1'b0});
    exp_b_q.push_back({32'hFFFFFFFF, 4'hF, 1'b0});
    push_b(32'hFF00FFAB, 1'b1, 1'b0, 6'd0);
    push_b(32'hFFFFFFFF, 1'b1, 1'b0, 6'd0);
    drain_b(40);
    quiet_b("b_nostuff_quiet");

    // T3: full word then a 7-bit final word
    exp_b_q.push_back({32'hAABBCCDD, 4'hF, 1'b0});
    exp_b_q.push_back({32'h1F000000, 4'h8, 1'b1});
    push_b(32'hAABBCCDD, 1'b1, 1'b0, 6'd0);
    push_b(32'h1E000000, 1'b0, 1'b1, 6'd7);
    drain_b(40);
    quiet_b("t3_quiet");

    // T5: empty final word after a full one
    exp_b_q.push_back({32'h11223344, 4'hF, 1'b0});
    exp_b_q.push_back({32'h00000000, 4'h0, 1'b1});
    push_b(32'h11223344, 1'b1, 1'b0, 6'd0);
    push_b(32'h00000000, 1'b0, 1'b1, 6'd0);
    drain_b(40);
    quiet_b("t5_quiet");

    // 20-bit final word: three lanes, last nibble padded with 1s
    exp_b_q.push_back({32'hABCDEF00, 4'hE, 1'b1});
    push_b(32'hABCDE000, 1'b0, 1'b1, 6'd20);
    drain_b(40);

    // valid and eof together act as an eof word
    exp_b_q.push_back({32'h7F000000, 4'h8, 1'b1});
    push_b(32'h7F000000, 1'b1, 1'b1, 6'd8);
    drain_b(40);

    // full-width final word: whole word, then an empty last marker
    exp_b_q.push_back({32'h55667788, 4'hF, 1'b0});
    exp_b_q.push_back({32'h00000000, 4'h0, 1'b1});
    push_b(32'h55667788, 1'b0, 1'b1, 6'd32);
    drain_b(40);
    quiet_b("b_final_quiet");
    chk("b_no_overflow", 64'(b_overflow), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
